// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 core.
// Drives fetch, IR, ALU strobe, data access, writeback and PC update; traps on illegal opcode or timeout.
module core_seq_ctrl #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  instr,
  input  logic             is_type_R,
  input  logic             is_type_I,
  input  logic             is_type_S,
  input  logic             is_type_B,
  input  logic             is_type_U,
  input  logic             is_type_J,
  input  logic             is_load,
  input  logic             branch_taken,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [XLEN-1:0]  r_instr;
  logic [CW-1:0]    r_waitCnt;
  logic [CW-1:0]    w_waitNext;
  logic             r_isS;
  logic             r_isB;
  logic             r_isLoad;
  logic             w_flagLoad;
  logic             w_irLoad;
  logic             w_trapSet;
  logic [1:0]       w_cause;
  logic             r_trap;
  logic [1:0]       r_trapCause;
  logic [CNT_W-1:0] r_retired;
  logic [2:0]       w_flagCount;
  logic             w_unusedBranch;

  assign w_unusedBranch = branch_taken;
  assign w_flagCount = {2'b00, is_type_R} + {2'b00, is_type_I} + {2'b00, is_type_S}
                     + {2'b00, is_type_B} + {2'b00, is_type_U} + {2'b00, is_type_J};

  assign state      = r_state;
  assign instr      = r_instr;
  assign trap       = r_trap;
  assign trap_cause = r_trapCause;
  assign retired    = r_retired;

  // Outputs are gated by rst so a handshake in flight drops the moment reset asserts.
  always_comb begin
    w_next     = r_state;
    w_waitNext = '0;
    w_flagLoad = 1'b0;
    w_irLoad   = 1'b0;
    w_trapSet  = 1'b0;
    w_cause    = 2'b00;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_en     = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            w_irLoad = 1'b1;
            w_next   = S_DECODE;
          end else if (r_waitCnt == LAST_WAIT) begin
            w_next    = S_TRAP;
            w_trapSet = 1'b1;
            w_cause   = 2'b10;
          end else begin
            w_waitNext = r_waitCnt + 1'b1;
          end
        end
        S_DECODE: begin
          w_flagLoad = 1'b1;
          if (w_flagCount != 3'd1) begin
            w_next    = S_TRAP;
            w_trapSet = 1'b1;
            w_cause   = 2'b01;
          end else begin
            w_next = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_en = 1'b1;
          if (r_isS || r_isLoad) begin
            w_next = S_MEM;
          end else if (r_isB) begin
            pc_we  = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = r_isS;
          if (dmem_ack) begin
            pc_we  = r_isS;
            w_next = r_isS ? S_FETCH : S_WB;
          end else if (r_waitCnt == LAST_WAIT) begin
            w_next    = S_TRAP;
            w_trapSet = 1'b1;
            w_cause   = 2'b11;
          end else begin
            w_waitNext = r_waitCnt + 1'b1;
          end
        end
        S_WB: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_FETCH;
        end
        S_TRAP: w_next = S_TRAP;
        default: begin
          w_next    = S_TRAP;
          w_trapSet = 1'b1;
          w_cause   = 2'b01;
        end
      endcase
    end
  end

  // Flags are latched in DECODE so later strobes never depend on decoder glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_instr     <= '0;
      r_waitCnt   <= '0;
      r_isS       <= 1'b0;
      r_isB       <= 1'b0;
      r_isLoad    <= 1'b0;
      r_trap      <= 1'b0;
      r_trapCause <= 2'b00;
      r_retired   <= '0;
    end else begin
      r_state   <= w_next;
      r_waitCnt <= w_waitNext;
      if (w_irLoad) r_instr <= imem_rdata;
      if (w_flagLoad) begin
        r_isS    <= is_type_S;
        r_isB    <= is_type_B;
        r_isLoad <= is_load;
      end
      if (w_trapSet) begin
        r_trap      <= 1'b1;
        r_trapCause <= w_cause;
      end
      if (pc_we) r_retired <= r_retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed testbench for core_seq_ctrl; a small opcode decoder model feeds the type flags back from instr.
module tb_core_seq_ctrl;

  localparam logic [31:0] ADD_I = 32'h002081B3;
  localparam logic [31:0] LW_I  = 32'h0000A103;
  localparam logic [31:0] SW_I  = 32'h0020A023;
  localparam logic [31:0] BEQ_I = 32'h00208463;
  localparam logic [31:0] ILL_I = 32'h0000007F;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        is_type_R, is_type_I, is_type_S, is_type_B, is_type_U, is_type_J;
  logic        is_load;
  logic        branch_taken;
  logic        alu_en;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic        pc_we;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  int checkCount;
  int errorCount;
  int reqCycles;
  int rfCount;

  core_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr),
    .is_type_R(is_type_R), .is_type_I(is_type_I), .is_type_S(is_type_S),
    .is_type_B(is_type_B), .is_type_U(is_type_U), .is_type_J(is_type_J),
    .is_load(is_load), .branch_taken(branch_taken),
    .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .state(state),
    .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference RV32 opcode decoder standing in for the real instruction decoder.
  always_comb begin
    logic [6:0] op;
    op        = instr[6:0];
    is_type_R = (op == 7'b0110011);
    is_type_I = (op == 7'b0010011) || (op == 7'b0000011) || (op == 7'b1100111);
    is_type_S = (op == 7'b0100011);
    is_type_B = (op == 7'b1100011);
    is_type_U = (op == 7'b0110111) || (op == 7'b0010111);
    is_type_J = (op == 7'b1101111);
    is_load   = (op == 7'b0000011);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic ia, input logic [31:0] rdata, input logic da);
    imem_ack   = ia;
    imem_rdata = rdata;
    dmem_ack   = da;
    #1;
  endtask

  task automatic fetchInstr(input logic [31:0] word);
    applyStimulus(1'b1, word, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    branch_taken = 1'b0;
    rst          = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    repeat (2) tick();
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_retired", retired, 32'd0);
    checkOutput("rst_trap", 32'(trap), 32'd0);
    checkOutput("rst_cause", 32'(trap_cause), 32'd0);
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);

    rst = 1'b0;
    #1;
    checkOutput("post_rst_imem_req", 32'(imem_req), 32'd1);

    // ADD: 0,1,2,4,0
    applyStimulus(1'b1, ADD_I, 1'b0);
    checkOutput("add_fetch_pc_we", 32'(pc_we), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("add_s1", 32'(state), 32'd1);
    checkOutput("add_ir", instr, ADD_I);
    checkOutput("add_dec_alu", 32'(alu_en), 32'd0);
    tick();
    checkOutput("add_s2", 32'(state), 32'd2);
    checkOutput("add_alu", 32'(alu_en), 32'd1);
    checkOutput("add_exec_rf", 32'(rf_we), 32'd0);
    tick();
    checkOutput("add_s4", 32'(state), 32'd4);
    checkOutput("add_rf_we", 32'(rf_we), 32'd1);
    checkOutput("add_pc_we", 32'(pc_we), 32'd1);
    tick();
    checkOutput("add_s0", 32'(state), 32'd0);
    checkOutput("add_retired", retired, 32'd1);

    // LW with dmem_ack delayed 3 cycles
    fetchInstr(LW_I);
    tick();
    tick();
    checkOutput("lw_mem", 32'(state), 32'd3);
    checkOutput("lw_we", 32'(dmem_we), 32'd0);
    reqCycles = 0;
    rfCount   = 0;
    for (int i = 0; i < 3; i++) begin
      if (dmem_req) reqCycles++;
      if (rf_we) rfCount++;
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    if (dmem_req) reqCycles++;
    checkOutput("lw_ack_pc_we", 32'(pc_we), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("lw_wb", 32'(state), 32'd4);
    checkOutput("lw_req_cycles", 32'(reqCycles), 32'd4);
    if (rf_we) rfCount++;
    tick();
    if (rf_we) rfCount++;
    checkOutput("lw_rf_count", 32'(rfCount), 32'd1);
    checkOutput("lw_retired", retired, 32'd2);

    // SW retires from MEM
    fetchInstr(SW_I);
    tick();
    tick();
    checkOutput("sw_mem", 32'(state), 32'd3);
    checkOutput("sw_we", 32'(dmem_we), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("sw_pc_we", 32'(pc_we), 32'd1);
    checkOutput("sw_rf_we", 32'(rf_we), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("sw_s0", 32'(state), 32'd0);
    checkOutput("sw_retired", retired, 32'd3);

    // BEQ retires from EXEC
    fetchInstr(BEQ_I);
    tick();
    checkOutput("beq_exec", 32'(state), 32'd2);
    checkOutput("beq_alu", 32'(alu_en), 32'd1);
    checkOutput("beq_pc_we", 32'(pc_we), 32'd1);
    checkOutput("beq_rf_we", 32'(rf_we), 32'd0);
    checkOutput("beq_dmem_req", 32'(dmem_req), 32'd0);
    tick();
    checkOutput("beq_s0", 32'(state), 32'd0);
    checkOutput("beq_retired", retired, 32'd4);

    // Reset asserted mid-MEM
    fetchInstr(LW_I);
    tick();
    tick();
    checkOutput("mid_mem_req", 32'(dmem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_req", 32'(dmem_req), 32'd0);
    checkOutput("mid_rst_state", 32'(state), 32'd0);
    checkOutput("mid_rst_retired", retired, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("resume_imem_req", 32'(imem_req), 32'd1);
    fetchInstr(ADD_I);
    repeat (3) tick();
    checkOutput("resume_retired", retired, 32'd1);

    // Illegal opcode
    fetchInstr(ILL_I);
    checkOutput("ill_decode", 32'(state), 32'd1);
    tick();
    checkOutput("ill_trap_state", 32'(state), 32'd7);
    checkOutput("ill_trap", 32'(trap), 32'd1);
    checkOutput("ill_cause", 32'(trap_cause), 32'd1);
    checkOutput("ill_imem_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, ADD_I, 1'b1);
      tick();
    end
    applyStimulus(1'b1, ADD_I, 1'b1);
    checkOutput("ill_hold_state", 32'(state), 32'd7);
    checkOutput("ill_hold_ir", instr, ILL_I);
    checkOutput("ill_hold_retired", retired, 32'd1);
    checkOutput("ill_hold_pc_we", 32'(pc_we), 32'd0);
    checkOutput("ill_hold_dmem_req", 32'(dmem_req), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Fetch timeout: no ack for 16 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("to_trap_cleared", 32'(trap), 32'd0);
    repeat (15) tick();
    checkOutput("to_still_fetch", 32'(state), 32'd0);
    tick();
    checkOutput("to_state", 32'(state), 32'd7);
    checkOutput("to_trap", 32'(trap), 32'd1);
    checkOutput("to_cause", 32'(trap_cause), 32'd2);

    // Ack on the 16th wait cycle wins over the timeout
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    repeat (15) tick();
    fetchInstr(ADD_I);
    checkOutput("ack16_state", 32'(state), 32'd1);
    checkOutput("ack16_trap", 32'(trap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
